// File: rtl/reversal_pkg.sv
// ---------------------------------------------------------------------------
// reversal_pkg
// Shared constants for the reversal pipeline: the width of the mode select
// field and the legal permutation mode codes. Codes above MODE_HALFSWAP are
// illegal and are passed through unmodified with the error flag raised.
// ---------------------------------------------------------------------------
package reversal_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_PASS        = 3'd0;
  localparam logic [MODE_W-1:0] MODE_BITREV      = 3'd1;
  localparam logic [MODE_W-1:0] MODE_BITREV_BYTE = 3'd2;
  localparam logic [MODE_W-1:0] MODE_BYTESWAP    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_HALFSWAP    = 3'd4;

endpackage

// File: rtl/reversal_perm.sv
// ---------------------------------------------------------------------------
// reversal_perm
// Purely combinational permutation network. Every candidate permutation is
// wired up in parallel and the mode code picks one of them.
//
// Parameters:
//   WIDTH     data width, power of two, multiple of 16
// Ports:
//   data      input  [WIDTH-1:0]   operand
//   mode      input  [MODE_W-1:0]  permutation select
//   perm_data output [WIDTH-1:0]   permuted operand
//   err       output               mode code is not a legal permutation
// ---------------------------------------------------------------------------
module reversal_perm
  import reversal_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  data,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  perm_data,
  output logic              err
);

  localparam int NBYTES = WIDTH / 8;
  localparam int HALF   = WIDTH / 2;

  logic [WIDTH-1:0] bitrev;
  logic [WIDTH-1:0] bitrev_byte;
  logic [WIDTH-1:0] byteswap;
  logic [WIDTH-1:0] halfswap;

  // Full-word bit reversal: bit i takes the mirror bit from the other end.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bitrev
    assign bitrev[i] = data[WIDTH-1-i];
  end

  // Per-byte networks: mirror bits within a byte, or move whole bytes to
  // the mirrored byte lane while keeping bit order inside each byte.
  for (genvar b = 0; b < NBYTES; b++) begin : g_byte
    for (genvar j = 0; j < 8; j++) begin : g_bit
      assign bitrev_byte[8*b+j] = data[8*b+7-j];
      assign byteswap[8*b+j]    = data[8*(NBYTES-1-b)+j];
    end
  end

  assign halfswap = {data[HALF-1:0], data[WIDTH-1:HALF]};

  // Mode select. Unknown codes fall back to the unmodified operand and
  // raise err so downstream logic can tell a pass-through from a fault.
  always_comb begin
    perm_data = data;
    err       = 1'b0;
    case (mode)
      MODE_PASS:        perm_data = data;
      MODE_BITREV:      perm_data = bitrev;
      MODE_BITREV_BYTE: perm_data = bitrev_byte;
      MODE_BYTESWAP:    perm_data = byteswap;
      MODE_HALFSWAP:    perm_data = halfswap;
      default: begin
        perm_data = data;
        err       = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/reversal_pipe.sv
// ---------------------------------------------------------------------------
// reversal_pipe
// Two-stage valid/ready pipeline applying a selectable bit/byte permutation.
// S1 captures the operand and mode; S2 captures the permuted result. Both
// stages advance independently so the pipe holds two words under stall and
// streams one word per cycle when downstream keeps out_ready high.
//
// Optional feature macro: REVERSAL_COUNT_EN adds the op_count port, a
// wrapping count of completed output transfers.
//
// Parameters:
//   WIDTH     data width, power of two, minimum 16, multiple of 16
//   MODE_W    width of the mode select field
// Ports:
//   clk       input                clock
//   rst       input                synchronous active-high reset
//   in_valid  input                operand and mode are valid
//   in_ready  output               block accepts an input this cycle
//   in_data   input  [WIDTH-1:0]   operand
//   in_mode   input  [MODE_W-1:0]  permutation select
//   out_valid output               result valid
//   out_ready input                downstream accepts the result
//   out_data  output [WIDTH-1:0]   permuted word
//   out_err   output               mode was illegal, out_data is the operand
//   op_count  output [31:0]        completed output transfers (optional)
// ---------------------------------------------------------------------------
module reversal_pipe
  import reversal_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MODE_W = reversal_pkg::MODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_err
`ifdef REVERSAL_COUNT_EN
  ,
  output logic [31:0]       op_count
`endif
);

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_data;
  logic [MODE_W-1:0] s1_mode;
  logic              s2_valid;
  logic [WIDTH-1:0]  s2_data;
  logic              s2_err;
  logic              s1_adv;
  logic              s2_adv;
  logic [WIDTH-1:0]  perm_data;
  logic              perm_err;

  // A stage may load when it is empty or when the stage after it is moving.
  // The only combinational path through the block is out_ready -> in_ready.
  assign s2_adv   = !s2_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: capture operand and mode only on an actual input transfer, so
  // later changes to in_mode cannot affect a word already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
      end
    end
  end

  reversal_perm #(
    .WIDTH (WIDTH)
  ) u_perm (
    .data      (s1_data),
    .mode      (s1_mode),
    .perm_data (perm_data),
    .err       (perm_err)
  );

  // Stage 2: holds the result steady while downstream stalls; the data and
  // err registers only load when a valid word moves up from S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= perm_data;
        s2_err  <= perm_err;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_err   = s2_err;

`ifdef REVERSAL_COUNT_EN
  // Completed-transfer counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= 32'd0;
    end else if (out_valid & out_ready) begin
      op_count <= op_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/reversal_pipe.md
Name: reversal_pipe

Overview:
- Parametrised, pipelined successor to the 32-bit reversal mux.
- Applies a selectable bit/byte permutation to a WIDTH-bit word.
- Uses a valid/ready handshake and a two-stage registered pipeline, so it can sit between the ALU operand path and the writeback mux without breaking timing.
- Includes full backpressure support and flags illegal mode codes.

Parameters:
- WIDTH, 32, data width. Power of two, minimum 16, multiple of 16.
- MODE_W, 3, width of the mode select field.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input word and mode are valid.
- in_ready  output  1  block can accept an input this cycle.
- in_data  input  WIDTH  operand.
- in_mode  input  MODE_W  permutation select.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  permuted word.
- out_err  output  1  mode code was illegal; out_data is the unmodified operand.
- op_count  output  32  completed output transfers. Present only with REVERSAL_COUNT_EN.

Behaviour:
- Mode codes:
  - 0 PASS: out = in.
  - 1 BITREV: out[i] = in[WIDTH-1-i].
  - 2 BITREV_BYTE: bits reversed inside each byte; byte order kept.
  - 3 BYTESWAP: byte order reversed (endian swap).
  - 4 HALFSWAP: upper and lower WIDTH/2 halves exchanged.
  - 5..7 illegal: behave as PASS with err = 1.
- Stage 1 (S1) registers in_data, in_mode and s1_valid on an input transfer (in_valid & in_ready).
- Stage 2 (S2) registers the permuted data, the err flag and s2_valid, computed combinationally from S1.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no other combinational in-to-out path).
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput: 1 word/cycle.
- Stall: while out_valid & !out_ready, out_data and out_err are held stable. S1 fills; the pipeline then holds 2 words and in_ready = 0. No word is lost or duplicated.
- Simultaneous events: an output transfer and an input transfer in the same cycle shift the pipeline by one with no bubble.
- Empty pipe: out_valid = 0 and in_ready = 1.
- in_mode is sampled only at the input transfer; later changes do not affect words in flight.
- Reset values: s1_valid = 0, s2_valid = 0, out_valid = 0, out_data = 0, out_err = 0, op_count = 0. Data registers in both stages clear to 0.
- Reset mid-operation drops all in-flight words. in_ready = 1 in the first cycle after reset deasserts.

Optional Feature:
- REVERSAL_COUNT_EN defined:
  - op_count port exists.
  - It increments by 1 on every out_valid & out_ready cycle and wraps from 0xFFFFFFFF to 0.
  - It is cleared by rst.
- REVERSAL_COUNT_EN not defined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package reversal_pkg holds:
  - the mode constants MODE_PASS=0, MODE_BITREV=1, MODE_BITREV_BYTE=2, MODE_BYTESWAP=3, MODE_HALFSWAP=4;
  - MODE_W.
- Sub-module reversal_perm(WIDTH) is purely combinational:
  - inputs: data, mode; outputs: permuted data, err.
  - Built from generate loops.
  - It is instantiated between S1 and S2.
- The top level holds only the handshake, the pipeline registers and the optional counter.

Test Plan (WIDTH = 32):
- BITREV 0x00000001, out_ready = 1 -> 0x80000000 two cycles after the transfer, err = 0. PASS 0xDEADBEEF -> 0xDEADBEEF.
- BITREV_BYTE 0x01020304 -> 0x8040C020. BYTESWAP 0x12345678 -> 0x78563412. HALFSWAP 0x12345678 -> 0x56781234.
- Mode 7 with 0xCAFEF00D -> out_data 0xCAFEF00D, out_err = 1. The next word, mode 1 0x00000001 -> 0x80000000, out_err = 0.
- Hold out_ready = 0 and offer 3 BYTESWAP words back to back -> 2 accepted, in_ready = 0 on the third, out_data stable. Release out_ready -> all 3 words emerge in order with correct values.
- Stream 8 words with out_ready = 1 -> 8 consecutive out_valid cycles, no bubble. With REVERSAL_COUNT_EN, op_count = 8.
- Pulse rst with 2 words in flight -> next cycle out_valid = 0, out_data = 0, in_ready = 1, op_count = 0. The dropped words never appear.
